// File: rtl/isolator_blip_pkg.sv
// isolator_blip_pkg: shared state encoding and widths for the isolator blip detector
package isolator_blip_pkg;
  localparam int WIDTH_W = 8;
  localparam int TS_W = 16;
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = 8'd255;
  typedef enum logic {ST_IDLE, ST_PULSE} state_t;
endpackage

// File: rtl/isolator_blip_detector_sync.sv
// isolator_sync: STAGES-deep synchroniser chain; every flop resets to the idle level
module isolator_sync #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk)
    if (!reset) sync_q <= {STAGES{IDLE_LEVEL}};
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/isolator_blip_detector.sv
// isolator_blip_detector: measures isolator pulse widths and flags pulses shorter than MIN_GOOD_WIDTH.
// Optional BLIP_TIMESTAMP_EN adds a free-running cycle counter and the blip_time output.
module isolator_blip_detector
  import isolator_blip_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   MIN_GOOD_WIDTH = 8,
  parameter logic IDLE_LEVEL     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iso_in,
  input  logic               clear,
  output logic               iso_level,
  output logic               blip_valid,
  output logic               good_valid,
  output logic [WIDTH_W-1:0] pulse_width,
  output logic [WIDTH_W-1:0] blip_count,
`ifdef BLIP_TIMESTAMP_EN
  output logic [TS_W-1:0]    blip_time,
`endif
  output logic               blip_seen
);
  state_t state_q, state_d;
  logic prev_q, prev_d, start, stop, ended, is_blip;
  logic [WIDTH_W-1:0] cnt_q, cnt_d, pulse_width_q, pulse_width_d, blip_count_q, blip_count_d;
  logic blip_valid_q, blip_valid_d, good_valid_q, good_valid_d, blip_seen_q, blip_seen_d;

  isolator_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(IDLE_LEVEL)) u_sync (
    .clk(clk), .reset(reset), .d(iso_in), .q(iso_level)
  );

  always_comb begin
    prev_d        = iso_level;
    start         = (iso_level != IDLE_LEVEL) && (prev_q == IDLE_LEVEL);
    stop          = (iso_level == IDLE_LEVEL) && (prev_q != IDLE_LEVEL);
    ended         = stop && (state_q == ST_PULSE);
    is_blip       = ended && (cnt_q < WIDTH_W'(MIN_GOOD_WIDTH));
    state_d       = (state_q == ST_IDLE && start) ? ST_PULSE : ended ? ST_IDLE : state_q;
    cnt_d         = (state_q == ST_IDLE && start) ? WIDTH_W'(1) :
                    (state_q == ST_PULSE && iso_level != IDLE_LEVEL && cnt_q != WIDTH_MAX) ? cnt_q + 1'b1 : cnt_q;
    blip_valid_d  = is_blip;
    good_valid_d  = ended && !is_blip;
    pulse_width_d = ended ? cnt_q : pulse_width_q;
    // clear overrides a coincident blip for the tally and sticky flag only
    blip_count_d  = clear ? '0 : (is_blip && blip_count_q != WIDTH_MAX) ? blip_count_q + 1'b1 : blip_count_q;
    blip_seen_d   = clear ? 1'b0 : blip_seen_q | is_blip;
  end

  always_ff @(posedge clk)
    if (!reset) begin
      state_q       <= ST_IDLE;
      prev_q        <= IDLE_LEVEL;
      cnt_q         <= '0;
      blip_valid_q  <= 1'b0;
      good_valid_q  <= 1'b0;
      pulse_width_q <= '0;
      blip_count_q  <= '0;
      blip_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      blip_valid_q  <= blip_valid_d;
      good_valid_q  <= good_valid_d;
      pulse_width_q <= pulse_width_d;
      blip_count_q  <= blip_count_d;
      blip_seen_q   <= blip_seen_d;
    end

  assign blip_valid  = blip_valid_q;
  assign good_valid  = good_valid_q;
  assign pulse_width = pulse_width_q;
  assign blip_count  = blip_count_q;
  assign blip_seen   = blip_seen_q;

`ifdef BLIP_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d, blip_time_q, blip_time_d;
  always_comb begin
    ts_d        = ts_q + 1'b1;
    blip_time_d = is_blip ? ts_q : blip_time_q;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      ts_q        <= '0;
      blip_time_q <= '0;
    end else begin
      ts_q        <= ts_d;
      blip_time_q <= blip_time_d;
    end
  assign blip_time = blip_time_q;
`endif
endmodule

// File: doc/isolator_blip_detector.md
# isolator_blip_detector

Monitors the digital output of a signal isolator and flags "blips": pulses away from the idle level that are shorter than a legal minimum width. It synchronises the asynchronous isolator output into the 33 MHz `clk` domain and measures each pulse width in clock cycles. It then classifies each pulse as good or blip and keeps a saturating blip tally plus a sticky flag. It sits directly upstream of `counter_for_isolator_blip_detection`, which consumes `blip_valid` as its count-enable.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on `iso_in`; legal range 2..4.
- `MIN_GOOD_WIDTH`, 8: pulses narrower than this many cycles are blips; legal range 2..255.
- `IDLE_LEVEL`, 1'b0: resting level of the isolator output.
- `clk`  in  1  single system clock, 33 MHz nominal; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `iso_in`  in  1  raw isolator output, asynchronous to `clk`.
- `clear`  in  1  synchronous clear of `blip_count` and `blip_seen`.
- `iso_level`  out  1  synchronised `iso_in` (last sync stage).
- `blip_valid`  out  1  one-cycle pulse: a blip has just ended.
- `good_valid`  out  1  one-cycle pulse: a legal pulse has just ended.
- `pulse_width`  out  8  width of the most recently ended pulse, in cycles; held until the next pulse ends.
- `blip_count`  out  8  number of blips since reset/clear; saturates at 255.
- `blip_seen`  out  1  sticky; set by any blip.
- `blip_time`  out  16  present only with `BLIP_TIMESTAMP_EN`; see Configuration.

## Operation
- Sync chain and `prev` register reset to `IDLE_LEVEL`.
- `start` = `iso_level` != `IDLE_LEVEL` and `prev` == `IDLE_LEVEL`.
- `stop` = `iso_level` == `IDLE_LEVEL` and `prev` != `IDLE_LEVEL`.
- FSM has two states, IDLE and PULSE.
  - IDLE -> PULSE on `start`; the width counter loads 1.
  - In PULSE, the counter increments each cycle `iso_level` stays non-idle, saturating at 255.
  - PULSE -> IDLE on `stop`.
  - On `stop`: `pulse_width` <= counter value. If the counter is below `MIN_GOOD_WIDTH`, pulse `blip_valid`, increment `blip_count` (saturating) and set `blip_seen`. Otherwise pulse `good_valid`.
- `blip_valid` and `good_valid` are mutually exclusive and never asserted in consecutive cycles. The minimum pulse + gap is 2 cycles.
- A pulse of 255 cycles or more reports width 255 and is always good.
- `clear` and a blip in the same cycle: `clear` wins (`blip_count` = 0, `blip_seen` = 0). `blip_valid` and `pulse_width` still report the blip.
- Reset mid-pulse: the pulse is discarded and no report is made. If `iso_in` is still non-idle after reset release, it counts as a new pulse start.
- Reset values: `iso_level` = `IDLE_LEVEL`; `blip_valid`, `good_valid`, `pulse_width`, `blip_count`, `blip_seen`, `blip_time` all 0; FSM in IDLE.

## Timing
- `iso_in` edge to `iso_level`: `SYNC_STAGES` rising edges.
- `iso_in` returning to idle to `blip_valid`/`good_valid` high: `SYNC_STAGES`+1 rising edges. The edge that first samples the idle level counts as edge 1.
- `iso_in` held non-idle for exactly W clock periods (synchronous stimulus) gives `pulse_width` = W.
- `blip_count` and `blip_seen` update on the same edge that raises `blip_valid`.

## Configuration
- `BLIP_TIMESTAMP_EN` defined:
  - adds a free-running 16-bit cycle counter (reset 0, wraps 65535 -> 0);
  - adds output `blip_time`, which latches the counter value on the edge that raises `blip_valid` and holds it until the next blip;
  - `clear` does not affect `blip_time`.
- Not defined: no counter, no `blip_time` port; all other behaviour is identical.

## Structure
- Shared package `isolator_blip_pkg` holds:
  - the state encoding (`ST_IDLE`, `ST_PULSE`);
  - `WIDTH_W` = 8, `TS_W` = 16, `WIDTH_MAX` = 255.
- One sub-module, `isolator_sync`: a `SYNC_STAGES`-deep flop chain with reset value `IDLE_LEVEL`.
- Classification, counters and FSM live in the top module.

## Test plan
- Reset held 200 ns with `iso_in` = 1 -> after release, `iso_level` goes to 1 after 2 edges. On return to 0, one `good_valid` or `blip_valid` reflecting the counted width. All outputs are 0 during reset.
- `iso_in` pulse of 3 cycles -> `blip_valid` 3 edges after the falling sample; `pulse_width` = 3, `blip_count` = 1, `blip_seen` = 1.
- Pulses of 7 and 8 cycles -> first gives `blip_valid` (width 7), second gives `good_valid` (width 8); `blip_count` increments only once.
- Pulse of 300 cycles -> `good_valid`, `pulse_width` = 255.
- 260 one-cycle pulses separated by 1-cycle gaps -> 260 `blip_valid` pulses; `blip_count` saturates at 255.
- `clear` asserted in the same cycle as `blip_valid` -> `blip_count` = 0, `blip_seen` = 0, `pulse_width` shows the blip width. With `BLIP_TIMESTAMP_EN`, `blip_time` equals the cycle-counter value at that edge.
